// File: rtl/simple_mips_pkg.sv
// simple_mips_pkg: shared register-file sizes and stall-vector encodings for the core pipeline
package simple_mips_pkg;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int PEND_W     = 2;
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;
  typedef logic [5:0] stall_t;
  localparam stall_t STALL_NONE     = 6'b000000;
  localparam stall_t STALL_HOLD_ID  = 6'b000111;
  localparam stall_t STALL_HOLD_EX  = 6'b001111;
  localparam stall_t STALL_HOLD_MEM = 6'b011111;
  function automatic stall_t stall_sel(input logic mem, input logic ex, input logic haz);
    return mem ? STALL_HOLD_MEM : ex ? STALL_HOLD_EX : haz ? STALL_HOLD_ID : STALL_NONE;
  endfunction
endpackage

// File: rtl/id_hazard_ctrl_if.sv
// id_hazard_ctrl_if: decode/EX/MEM/WB signals seen by the hazard controller and its stall outputs
interface id_hazard_ctrl_if import simple_mips_pkg::*; #(parameter int ADDR_W = REG_ADDR_W);
  logic              id_valid;
  logic              id_re_1;
  logic              id_re_2;
  logic [ADDR_W-1:0] id_raddr_1;
  logic [ADDR_W-1:0] id_raddr_2;
  logic              id_we;
  logic [ADDR_W-1:0] id_waddr;
  logic              ex_stall_req;
  logic              mem_stall_req;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_waddr;
  stall_t            stall;
  logic              id_issue;
  logic              hazard;
  logic              err;
  logic [31:0]       stall_cnt;
  modport master (
    output id_valid, id_re_1, id_re_2, id_raddr_1, id_raddr_2, id_we, id_waddr,
    output ex_stall_req, mem_stall_req, wb_we, wb_waddr,
    input  stall, id_issue, hazard, err, stall_cnt
  );
  modport slave (
    input  id_valid, id_re_1, id_re_2, id_raddr_1, id_raddr_2, id_we, id_waddr,
    input  ex_stall_req, mem_stall_req, wb_we, wb_waddr,
    output stall, id_issue, hazard, err, stall_cnt
  );
endinterface

// File: rtl/hazard_pend_cell.sv
// hazard_pend_cell: pending-write counter for one register; busy/full reflect same-cycle WB retirement
module hazard_pend_cell import simple_mips_pkg::*; #(parameter int PEND_W = simple_mips_pkg::PEND_W) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic busy,
  output logic full,
  output logic err
);
  localparam logic [PEND_W-1:0] MAX = '1;
  logic [PEND_W-1:0] pend;
  logic [PEND_W-1:0] eff;
  // write-through regfile: a retirement this cycle already satisfies readers
  assign eff  = pend - PEND_W'(dec && pend != '0);
  assign busy = rst && eff != '0;
  assign full = rst && eff == MAX;
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend <= '0;
      err  <= 1'b0;
    end else begin
      if (inc && !dec) pend <= pend + PEND_W'(1);
      else if (dec && !inc && pend != '0) pend <= pend - PEND_W'(1);
      if (dec && pend == '0) err <= 1'b1;
    end
  end
endmodule

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: RAW/saturation hazard scoreboard and pipeline stall merge for the ID stage.
// HAZ_STALL_CNT_EN builds a saturating count of ID-stall cycles; otherwise stall_cnt reads 0.
module id_hazard_ctrl #(
  parameter int NUM_REGS = simple_mips_pkg::NUM_REGS,
  parameter int ADDR_W   = simple_mips_pkg::REG_ADDR_W,
  parameter int PEND_W   = simple_mips_pkg::PEND_W
) (
  input logic              clk,
  input logic              rst,
  id_hazard_ctrl_if.slave  bus
);
  import simple_mips_pkg::*;
  logic [NUM_REGS-1:0] busy, full, inc, dec, err_v;
  logic raw, sat;
  assign busy[0]  = 1'b0;
  assign full[0]  = 1'b0;
  assign inc[0]   = 1'b0;
  assign dec[0]   = 1'b0;
  assign err_v[0] = 1'b0;
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    assign inc[r] = bus.id_issue && bus.id_we && bus.id_waddr == ADDR_W'(r);
    assign dec[r] = bus.wb_we && bus.wb_waddr == ADDR_W'(r);
    hazard_pend_cell #(.PEND_W(PEND_W)) u_cell (
      .clk  (clk),
      .rst  (rst),
      .inc  (inc[r]),
      .dec  (dec[r]),
      .busy (busy[r]),
      .full (full[r]),
      .err  (err_v[r])
    );
  end
  assign raw = bus.id_valid && ((bus.id_re_1 && busy[bus.id_raddr_1]) ||
                                (bus.id_re_2 && busy[bus.id_raddr_2]));
  assign sat = bus.id_valid && bus.id_we && full[bus.id_waddr];
  assign bus.hazard   = raw || sat;
  assign bus.stall    = stall_sel(bus.mem_stall_req, bus.ex_stall_req, bus.hazard);
  assign bus.id_issue = bus.id_valid && !bus.stall[STALL_ID];
  assign bus.err      = |err_v;
`ifdef HAZ_STALL_CNT_EN
  logic [31:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst) cnt <= '0;
    else if (bus.stall[STALL_ID] && cnt != '1) cnt <= cnt + 32'd1;
  end
  assign bus.stall_cnt = cnt;
`else
  assign bus.stall_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl: scoreboard bench; a reference model queues expected outputs per driven cycle
module tb_id_hazard_ctrl;
  typedef struct packed {
    logic [5:0]  stall;
    logic        issue;
    logic        hazard;
    logic        err;
    logic [31:0] cnt;
  } exp_t;
  localparam int PMAX = 3;
  logic clk = 1'b0;
  logic rst;
  id_hazard_ctrl_if #(.ADDR_W(5)) bus ();
  id_hazard_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int pend [32];
  logic m_err;
  logic [31:0] m_cnt;
  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  exp_t o;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic int eff(input int r);
    if (r == 0) return 0;
    return pend[r] - ((bus.wb_we && int'(bus.wb_waddr) == r && pend[r] > 0) ? 1 : 0);
  endfunction
  task automatic drive(input bit v, input bit re1, input int a1, input bit re2, input int a2,
                       input bit we, input int wa, input bit exs, input bit mems,
                       input bit wbwe, input int wba);
    bus.id_valid = v;
    bus.id_re_1 = re1;
    bus.id_raddr_1 = 5'(a1);
    bus.id_re_2 = re2;
    bus.id_raddr_2 = 5'(a2);
    bus.id_we = we;
    bus.id_waddr = 5'(wa);
    bus.ex_stall_req = exs;
    bus.mem_stall_req = mems;
    bus.wb_we = wbwe;
    bus.wb_waddr = 5'(wba);
  endtask
  task automatic tick(output exp_t obs);
    exp_t e;
    bit raw, sat, inc, dec;
    raw = rst && bus.id_valid && ((bus.id_re_1 && eff(int'(bus.id_raddr_1)) != 0) ||
                                  (bus.id_re_2 && eff(int'(bus.id_raddr_2)) != 0));
    sat = rst && bus.id_valid && bus.id_we && bus.id_waddr != 0 && eff(int'(bus.id_waddr)) == PMAX;
    e.hazard = raw || sat;
    e.stall = bus.mem_stall_req ? 6'b011111 : bus.ex_stall_req ? 6'b001111 :
              e.hazard ? 6'b000111 : 6'b000000;
    e.issue = bus.id_valid && !e.stall[2];
    e.err = m_err;
    e.cnt = m_cnt;
    q.push_back(e);
    @(negedge clk);
    obs.stall = bus.stall;
    obs.issue = bus.id_issue;
    obs.hazard = bus.hazard;
    obs.err = bus.err;
    obs.cnt = bus.stall_cnt;
    e = q.pop_front();
    check("stall", 32'(obs.stall), 32'(e.stall));
    check("issue", 32'(obs.issue), 32'(e.issue));
    check("hazard", 32'(obs.hazard), 32'(e.hazard));
    check("err", 32'(obs.err), 32'(e.err));
    check("stall_cnt", obs.cnt, e.cnt);
    if (!rst) begin
      foreach (pend[i]) pend[i] = 0;
      m_err = 1'b0;
      m_cnt = '0;
    end else begin
      inc = e.issue && bus.id_we && bus.id_waddr != 0;
      dec = bus.wb_we && bus.wb_waddr != 0;
      if (dec && pend[bus.wb_waddr] == 0) m_err = 1'b1;
      if (!(inc && dec && bus.id_waddr == bus.wb_waddr)) begin
        if (inc) pend[bus.id_waddr]++;
        if (dec && pend[bus.wb_waddr] > 0) pend[bus.wb_waddr]--;
      end
`ifdef HAZ_STALL_CNT_EN
      if (e.stall[2] && m_cnt != '1) m_cnt++;
`endif
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    foreach (pend[i]) pend[i] = 0;
    m_err = 1'b0;
    m_cnt = '0;
    rst = 1'b0;
    idle();
    @(posedge clk);
    #1;
    tick(o);
    check("rst_stall", 32'(o.stall), 32'h0);
    rst = 1'b1;
    tick(o);
    check("rst_err", 32'(o.err), 32'h0);
    check("rst_cnt", o.cnt, 32'h0);
    // 1: ori r1 then dependent read
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    tick(o);
    check("t1_issue_w", 32'(o.issue), 32'h1);
    drive(1, 1, 1, 0, 0, 1, 2, 0, 0, 0, 0);
    tick(o);
    check("t1_haz", 32'(o.hazard), 32'h1);
    check("t1_vec", 32'(o.stall), 32'h07);
    check("t1_hold", 32'(o.issue), 32'h0);
    tick(o);
    check("t1_hold2", 32'(o.issue), 32'h0);
    drive(1, 1, 1, 0, 0, 1, 2, 0, 0, 1, 1);
    tick(o);
    check("t1_release", 32'(o.issue), 32'h1);
    // 2: same-cycle retirement of r3
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    tick(o);
    drive(1, 0, 0, 1, 3, 0, 0, 0, 0, 1, 3);
    tick(o);
    check("t2_haz", 32'(o.hazard), 32'h0);
    check("t2_issue", 32'(o.issue), 32'h1);
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(o);
    check("t2_clear", 32'(o.hazard), 32'h0);
    // 3: stall priority with r2 still pending
    drive(1, 1, 2, 0, 0, 0, 0, 1, 1, 0, 0);
    tick(o);
    check("t3_mem", 32'(o.stall), 32'h1f);
    drive(1, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0);
    tick(o);
    check("t3_ex", 32'(o.stall), 32'h0f);
    drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(o);
    check("t3_haz", 32'(o.stall), 32'h07);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    tick(o);
    // 4: saturate r5
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
      tick(o);
      check("t4_fill", 32'(o.issue), 32'h1);
    end
    tick(o);
    check("t4_sat", 32'(o.hazard), 32'h1);
    check("t4_sat_hold", 32'(o.issue), 32'h0);
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 1, 5);
    tick(o);
    check("t4_release", 32'(o.issue), 32'h1);
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    tick(o);
    check("t4_full3", 32'(o.issue), 32'h0);
    // 5: spurious retire of r7, r0 traffic
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
    tick(o);
    check("t5_err_pre", 32'(o.err), 32'h0);
    drive(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(o);
      check("t5_err", 32'(o.err), 32'h1);
      check("t5_r0", 32'(o.issue), 32'h1);
    end
    // 6: reset with r2 pending twice
    drive(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
    tick(o);
    tick(o);
    drive(1, 1, 2, 1, 5, 0, 0, 0, 0, 0, 0);
    tick(o);
    check("t6_pre", 32'(o.hazard), 32'h1);
    rst = 1'b0;
    tick(o);
    check("t6_in_rst", 32'(o.issue), 32'h1);
    rst = 1'b1;
    tick(o);
    check("t6_err", 32'(o.err), 32'h0);
    check("t6_cnt", o.cnt, 32'h0);
    check("t6_nohaz", 32'(o.hazard), 32'h0);
    // stall counter: four hazard cycles on r9
    drive(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0);
    tick(o);
    drive(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(o);
    drive(1, 1, 9, 0, 0, 0, 0, 0, 0, 1, 9);
    tick(o);
    check("cnt_issue", 32'(o.issue), 32'h1);
    idle();
    tick(o);
`ifdef HAZ_STALL_CNT_EN
    check("cnt_four", o.cnt, 32'd4);
`else
    check("cnt_off", o.cnt, 32'd0);
`endif
    for (int i = 0; i < 12; i++) begin
      drive(1, 1, $urandom_range(0, 12), $urandom_range(0, 1), $urandom_range(0, 12),
            $urandom_range(0, 1), $urandom_range(0, 12), $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 1), $urandom_range(0, 12));
      tick(o);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
